// File: rtl/perceptron_trainer.sv
// perceptron_trainer: applies the perceptron learning rule to the four samples
// of a 2-input boolean truth table. It produces sign-magnitude weights for the
// downstream neuron.
// Optional feature: define PERCEPTRON_TRAINER_ERRCNT_EN to add err_cnt_o, the
// per-epoch count of misclassified samples.
module perceptron_trainer #(
  parameter int                 Q_M        = 15,
  parameter int                 Q_N        = 16,
  parameter logic [Q_M+Q_N:0]   LR         = 32'h0000_8000,
  parameter logic [Q_M+Q_N:0]   W1_INIT    = '0,
  parameter logic [Q_M+Q_N:0]   W2_INIT    = '0,
  parameter logic [Q_M+Q_N:0]   WB_INIT    = '0,
  parameter int                 MAX_EPOCHS = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              start_i,
  input  logic [3:0]                        target_i,
  output logic [Q_M+Q_N:0]                  w1_o,
  output logic [Q_M+Q_N:0]                  w2_o,
  output logic [Q_M+Q_N:0]                  wb_o,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              converged_o,
  output logic [$clog2(MAX_EPOCHS+1)-1:0]   epoch_o
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
  ,
  output logic [2:0]                        err_cnt_o
`endif
);

  localparam int W = 1 + Q_M + Q_N;
  localparam int E = $clog2(MAX_EPOCHS + 1);

  typedef logic signed [W-1:0] wt_t;   // weight, two's complement
  typedef logic signed [W:0]   wx_t;   // one extra bit for the update step
  typedef logic signed [W+1:0] sum_t;  // room for the sum of three weights

  // Largest representable magnitude; updates clamp here instead of wrapping.
  localparam wx_t SAT_P = wx_t'({2'b00, {(W-1){1'b1}}});
  localparam wx_t SAT_N = -SAT_P;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EVAL,
    S_UPDATE,
    S_CHECK,
    S_DONE
  } state_t;

  // Sign-magnitude to two's complement. A negative zero becomes zero.
  function automatic wt_t sm_to_tc(input logic [W-1:0] v);
    wt_t mag;
    mag = wt_t'({1'b0, v[W-2:0]});
    return v[W-1] ? -mag : mag;
  endfunction

  // Two's complement to sign-magnitude. Values never reach -2^(W-1).
  function automatic logic [W-1:0] tc_to_sm(input wt_t v);
    return v[W-1] ? {1'b1, (W-1)'(-v)} : {1'b0, v[W-2:0]};
  endfunction

  // Apply the error term e (+1, 0 or -1, 2-bit signed) scaled by LR when the
  // input is active, then saturate the result.
  function automatic wt_t sat_step(input wt_t w, input logic [1:0] e, input logic en);
    wx_t t;
    wx_t lr_x;
    lr_x = wx_t'({2'b00, LR[W-2:0]});
    t    = {w[W-1], w};
    if (en && e == 2'b01) begin
      t = t + lr_x;
    end else if (en && e == 2'b11) begin
      t = t - lr_x;
    end
    if (t > SAT_P) begin
      t = SAT_P;
    end else if (t < SAT_N) begin
      t = SAT_N;
    end
    return (W)'(t);
  endfunction

  state_t       state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic         err_flag_q, err_flag_d;
  logic [1:0]   e_q, e_d;
  logic [3:0]   target_q, target_d;
  wt_t          w1_q, w1_d;
  wt_t          w2_q, w2_d;
  wt_t          wb_q, wb_d;
  logic [E-1:0] epoch_q, epoch_d;
  logic         converged_q, converged_d;
  sum_t         sum;
  logic         y;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
  logic [2:0]   cnt_q, cnt_d;
  logic [2:0]   err_cnt_q, err_cnt_d;
`endif

  // Next-state logic: sequences the samples, evaluates, updates the weights and ends the epoch.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    err_flag_d  = err_flag_q;
    e_d         = e_q;
    target_d    = target_q;
    w1_d        = w1_q;
    w2_d        = w2_q;
    wb_d        = wb_q;
    epoch_d     = epoch_q;
    converged_d = converged_q;
    sum         = '0;
    y           = 1'b0;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
    cnt_d       = cnt_q;
    err_cnt_d   = err_cnt_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          state_d     = S_EVAL;
          idx_d       = 2'd0;
          err_flag_d  = 1'b0;
          target_d    = target_i;
          epoch_d     = '0;
          converged_d = 1'b0;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
          cnt_d       = 3'd0;
`endif
        end
      end
      S_EVAL: begin
        sum = (idx_q[1] ? {{2{w1_q[W-1]}}, w1_q} : sum_t'(0))
            + (idx_q[0] ? {{2{w2_q[W-1]}}, w2_q} : sum_t'(0))
            + {{2{wb_q[W-1]}}, wb_q};
        y   = (sum > sum_t'(0));
        // e = target - y, encoded as a 2-bit signed value.
        if (target_q[idx_q]) begin
          e_d = y ? 2'b00 : 2'b01;
        end else begin
          e_d = y ? 2'b11 : 2'b00;
        end
        state_d = S_UPDATE;
      end
      S_UPDATE: begin
        if (e_q != 2'b00) begin
          err_flag_d = 1'b1;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
          cnt_d      = cnt_q + 3'd1;
`endif
        end
        w1_d = sat_step(w1_q, e_q, idx_q[1]);
        w2_d = sat_step(w2_q, e_q, idx_q[0]);
        wb_d = sat_step(wb_q, e_q, 1'b1);
        if (idx_q == 2'd3) begin
          state_d = S_CHECK;
        end else begin
          idx_d   = idx_q + 2'd1;
          state_d = S_EVAL;
        end
      end
      S_CHECK: begin
        epoch_d = epoch_q + {{(E-1){1'b0}}, 1'b1};
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
        err_cnt_d = cnt_q;
        cnt_d     = 3'd0;
`endif
        if (!err_flag_q) begin
          state_d     = S_DONE;
          converged_d = 1'b1;
        end else if ((int'(epoch_q) + 1) == MAX_EPOCHS) begin
          state_d     = S_DONE;
          converged_d = 1'b0;
        end else begin
          state_d    = S_EVAL;
          idx_d      = 2'd0;
          err_flag_d = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register; reset restores the initial weights and aborts training.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= 2'd0;
      err_flag_q  <= 1'b0;
      e_q         <= 2'b00;
      target_q    <= 4'd0;
      w1_q        <= sm_to_tc(W1_INIT);
      w2_q        <= sm_to_tc(W2_INIT);
      wb_q        <= sm_to_tc(WB_INIT);
      epoch_q     <= '0;
      converged_q <= 1'b0;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
      cnt_q       <= 3'd0;
      err_cnt_q   <= 3'd0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      err_flag_q  <= err_flag_d;
      e_q         <= e_d;
      target_q    <= target_d;
      w1_q        <= w1_d;
      w2_q        <= w2_d;
      wb_q        <= wb_d;
      epoch_q     <= epoch_d;
      converged_q <= converged_d;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
      cnt_q       <= cnt_d;
      err_cnt_q   <= err_cnt_d;
`endif
    end
  end

  assign w1_o        = tc_to_sm(w1_q);
  assign w2_o        = tc_to_sm(w2_q);
  assign wb_o        = tc_to_sm(wb_q);
  assign busy_o      = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done_o      = (state_q == S_DONE);
  assign converged_o = converged_q;
  assign epoch_o     = epoch_q;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
  assign err_cnt_o   = err_cnt_q;
`endif

endmodule

// File: tb/tb_perceptron_trainer.sv
// Testbench for perceptron_trainer. Instance u0 uses the default parameters.
// Instance u1 uses the saturating configuration (LR and W1_INIT at full scale).
module tb_perceptron_trainer;

  localparam longint MAXV = 64'sd2147483647;

  typedef struct packed {
    logic [31:0]      w1;
    logic [31:0]      w2;
    logic [31:0]      wb;
    logic [4:0]       epochs;
    logic             conv;
    logic [15:0][2:0] errs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start [2];
  logic [3:0]  tgt;
  logic [31:0] w1 [2];
  logic [31:0] w2 [2];
  logic [31:0] wb [2];
  logic        busy [2];
  logic        done [2];
  logic        conv [2];
  logic [4:0]  epoch [2];
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
  logic [2:0]  errc [2];
`endif

  int     total = 0;
  int     bad = 0;
  exp_t   sb[$];
  longint m_w [2][3];
  longint m_lr [2];

  always #5 clk = ~clk;

  perceptron_trainer u0 (
    .clk_i(clk), .rst_i(rst), .start_i(start[0]), .target_i(tgt),
    .w1_o(w1[0]), .w2_o(w2[0]), .wb_o(wb[0]),
    .busy_o(busy[0]), .done_o(done[0]), .converged_o(conv[0]), .epoch_o(epoch[0])
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
    , .err_cnt_o(errc[0])
`endif
  );

  perceptron_trainer #(.LR(32'h7FFF_FFFF), .W1_INIT(32'h7FFF_FFFF)) u1 (
    .clk_i(clk), .rst_i(rst), .start_i(start[1]), .target_i(tgt),
    .w1_o(w1[1]), .w2_o(w2[1]), .wb_o(wb[1]),
    .busy_o(busy[1]), .done_o(done[1]), .converged_o(conv[1]), .epoch_o(epoch[1])
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
    , .err_cnt_o(errc[1])
`endif
  );

  function automatic logic [31:0] to_sm(input longint v);
    logic [30:0] m;
    m = (v < 0) ? 31'(-v) : 31'(v);
    return {(v < 0) ? 1'b1 : 1'b0, m};
  endfunction

  function automatic longint from_sm(input logic [31:0] v);
    longint m;
    m = longint'(v[30:0]);
    return v[31] ? -m : m;
  endfunction

  function automatic longint sat(input longint v);
    if (v > MAXV) return MAXV;
    if (v < -MAXV) return -MAXV;
    return v;
  endfunction

  // Reference training run on the model weights of one instance.
  task automatic model_train(input int inst, input logic [3:0] t, output exp_t x);
    longint s;
    int y, e, nerr, ep;
    bit fin;
    x = '0;
    ep = 0;
    fin = 0;
    while (!fin) begin
      nerr = 0;
      for (int i = 0; i < 4; i++) begin
        s = (i[1] ? m_w[inst][0] : 0) + (i[0] ? m_w[inst][1] : 0) + m_w[inst][2];
        y = (s > 0) ? 1 : 0;
        e = int'(t[i]) - y;
        if (e != 0) begin
          nerr++;
          if (i[1]) m_w[inst][0] = sat(m_w[inst][0] + e * m_lr[inst]);
          if (i[0]) m_w[inst][1] = sat(m_w[inst][1] + e * m_lr[inst]);
          m_w[inst][2] = sat(m_w[inst][2] + e * m_lr[inst]);
        end
      end
      x.errs[ep] = nerr[2:0];
      ep++;
      if (nerr == 0) begin
        x.conv = 1'b1;
        fin = 1;
      end else if (ep == 16) begin
        fin = 1;
      end
    end
    x.epochs = ep[4:0];
    x.w1 = to_sm(m_w[inst][0]);
    x.w2 = to_sm(m_w[inst][1]);
    x.wb = to_sm(m_w[inst][2]);
  endtask

  task automatic model_reset();
    m_w[0][0] = 0; m_w[0][1] = 0; m_w[0][2] = 0;
    m_w[1][0] = MAXV; m_w[1][1] = 0; m_w[1][2] = 0;
    m_lr[0] = 32768;
    m_lr[1] = MAXV;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One training transaction: push the expectation, start, follow the run, pop and compare.
  task automatic run_train(input int inst, input logic [3:0] t, input bit pulse_mid, input bit or_const);
    exp_t x, got;
    int cyc, busy_n;
    model_train(inst, t, x);
    if (or_const) begin
      x = '0;
      x.w1 = 32'h0000_8000; x.w2 = 32'h0000_8000; x.wb = 32'h0;
      x.epochs = 5'd4; x.conv = 1'b1;
      x.errs[0] = 3'd1; x.errs[1] = 3'd2; x.errs[2] = 3'd1; x.errs[3] = 3'd0;
    end
    sb.push_back(x);
    @(negedge clk);
    tgt = t;
    start[inst] = 1'b1;
    @(posedge clk);
    #1;
    start[inst] = 1'b0;
    cyc = 0;
    busy_n = busy[inst] ? 1 : 0;
    while (!done[inst] && cyc < 400) begin
      if (cyc == 2) tgt = ~t;
      start[inst] = (pulse_mid && cyc == 3) ? 1'b1 : 1'b0;
      @(posedge clk);
      #1;
      cyc++;
      if (busy[inst]) busy_n++;
`ifdef PERCEPTRON_TRAINER_ERRCNT_EN
      if (cyc % 9 == 0 && cyc <= 144) begin
        total++;
        if (errc[inst] !== x.errs[cyc / 9 - 1]) begin
          bad++;
          $display("FAIL err_cnt inst=%0d epoch=%0d got=%0d exp=%0d", inst, cyc / 9, errc[inst], x.errs[cyc / 9 - 1]);
        end
      end
`endif
    end
    start[inst] = 1'b0;
    got = sb.pop_front();
    $display("txn inst=%0d tgt=%b cycles=%0d epoch=%0d conv=%0d w1=%h w2=%h wb=%h", inst, t, cyc, epoch[inst], conv[inst], w1[inst], w2[inst], wb[inst]);
    total++;
    if (done[inst] !== 1'b1) begin bad++; $display("FAIL done_timeout inst=%0d got=%b exp=1", inst, done[inst]); end
    total++;
    if (cyc !== 9 * int'(got.epochs)) begin bad++; $display("FAIL done_latency inst=%0d got=%0d exp=%0d", inst, cyc, 9 * int'(got.epochs)); end
    total++;
    if (busy_n !== 9 * int'(got.epochs)) begin bad++; $display("FAIL busy_cycles inst=%0d got=%0d exp=%0d", inst, busy_n, 9 * int'(got.epochs)); end
    total++;
    if (epoch[inst] !== got.epochs) begin bad++; $display("FAIL epoch inst=%0d got=%0d exp=%0d", inst, epoch[inst], got.epochs); end
    total++;
    if (conv[inst] !== got.conv) begin bad++; $display("FAIL converged inst=%0d got=%b exp=%b", inst, conv[inst], got.conv); end
    total++;
    if (w1[inst] !== got.w1) begin bad++; $display("FAIL w1 inst=%0d got=%h exp=%h", inst, w1[inst], got.w1); end
    total++;
    if (w2[inst] !== got.w2) begin bad++; $display("FAIL w2 inst=%0d got=%h exp=%h", inst, w2[inst], got.w2); end
    total++;
    if (wb[inst] !== got.wb) begin bad++; $display("FAIL wb inst=%0d got=%h exp=%h", inst, wb[inst], got.wb); end
  endtask

  task automatic check_reset_vals(input string tag);
    logic [31:0] ew1;
    for (int k = 0; k < 2; k++) begin
      ew1 = (k == 1) ? 32'h7FFF_FFFF : 32'h0;
      total++;
      if (w1[k] !== ew1 || w2[k] !== 32'h0 || wb[k] !== 32'h0) begin
        bad++;
        $display("FAIL %s_weights inst=%0d got=%h/%h/%h exp=%h/0/0", tag, k, w1[k], w2[k], wb[k], ew1);
      end
      total++;
      if ({busy[k], done[k], conv[k], epoch[k]} !== 8'h00) begin
        bad++;
        $display("FAIL %s_flags inst=%0d got busy=%b done=%b conv=%b epoch=%0d exp=0", tag, k, busy[k], done[k], conv[k], epoch[k]);
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    check_reset_vals("reset");
  endtask

  task automatic test_or();
    run_train(0, 4'b1110, 1'b0, 1'b1);
  endtask

  task automatic test_back_to_back();
    run_train(0, 4'b1110, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    @(negedge clk);
    tgt = 4'b1110;
    start[0] = 1'b1;
    @(posedge clk);
    #1;
    start[0] = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_reset_vals("reset_mid");
    rst = 1'b0;
    model_reset();
    run_train(0, 4'b1110, 1'b0, 1'b1);
  endtask

  task automatic test_xor();
    logic [31:0] e1, e2, eb;
    do_reset();
    run_train(0, 4'b0110, 1'b0, 1'b0);
    e1 = to_sm(m_w[0][0]); e2 = to_sm(m_w[0][1]); eb = to_sm(m_w[0][2]);
    repeat (5) begin
      @(posedge clk);
      #1;
      total++;
      if (w1[0] !== e1 || w2[0] !== e2 || wb[0] !== eb || done[0] !== 1'b1) begin
        bad++;
        $display("FAIL done_stable got=%h/%h/%h done=%b exp=%h/%h/%h done=1", w1[0], w2[0], wb[0], done[0], e1, e2, eb);
      end
    end
  endtask

  task automatic test_and();
    logic [3:0] t_and;
    longint s;
    logic y;
    t_and = 4'b1000;
    do_reset();
    run_train(0, t_and, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      s = (i[1] ? from_sm(w1[0]) : 0) + (i[0] ? from_sm(w2[0]) : 0) + from_sm(wb[0]);
      y = (s > 0);
      total++;
      if (y !== t_and[i]) begin
        bad++;
        $display("FAIL and_neuron x=%0d got=%b exp=%b", i, y, t_and[i]);
      end
    end
  endtask

  task automatic test_saturation();
    do_reset();
    run_train(1, 4'b1000, 1'b0, 1'b0);
    run_train(1, 4'b1110, 1'b0, 1'b0);
    run_train(1, 4'b0001, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    start[0] = 1'b0;
    start[1] = 1'b0;
    tgt = 4'd0;
    model_reset();
    test_reset();
    test_or();
    test_back_to_back();
    test_reset_mid();
    test_xor();
    test_and();
    test_saturation();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
